// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle 16-bit processor: opcodes, ALU ops,
// bus select codes and instruction field extraction used by datapath and controller.
package mc_pkg;

    localparam int unsigned DataW = 16;
    localparam int unsigned NumRegs = 16;

    typedef enum logic [1:0] {
        OpR   = 2'd0,
        OpBeq = 2'd1,
        OpLd  = 2'd2,
        OpSd  = 2'd3
    } opcode_e;

    localparam logic [1:0] AluAdd = 2'b00;
    localparam logic [1:0] AluSub = 2'b01;
    localparam logic [1:0] AluOr  = 2'b10;
    localparam logic [1:0] AluAnd = 2'b11;

    // Address bus (db_0) sources
    localparam logic [3:0] Db0Pc    = 4'b0000;
    localparam logic [3:0] Db0Rs1   = 4'b0010;
    localparam logic [3:0] Db0Rs2   = 4'b0011;
    localparam logic [3:0] Db0Alu   = 4'b0101;
    localparam logic [3:0] Db0PcMux = 4'b0110;
    localparam logic [3:0] Db0Rd    = 4'b0111;
    localparam logic [3:0] Db0Tr1   = 4'b1011;

    // Data bus (db_1) sources
    localparam logic [3:0] Db1Pc    = 4'b0000;
    localparam logic [3:0] Db1Ipr   = 4'b0001;
    localparam logic [3:0] Db1RfA   = 4'b0010;
    localparam logic [3:0] Db1RfB   = 4'b0011;
    localparam logic [3:0] Db1Off   = 4'b0100;
    localparam logic [3:0] Db1Alu   = 4'b0101;
    localparam logic [3:0] Db1Tr2   = 4'b1010;
    localparam logic [3:0] Db1Tr1   = 4'b1011;
    localparam logic [3:0] Db1DmRd  = 4'b1110;

    typedef struct packed {
        opcode_e     opcode;
        logic [1:0]  aluop;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] offset;
    } instr_fields_t;

    function automatic logic [3:0] field_rd(input logic [15:0] ir);
        return ir[11:8];
    endfunction

    // ld moves rs1 to the low nibble to make room for its offset
    function automatic logic [3:0] field_rs1(input logic [15:0] ir);
        return (opcode_e'(ir[15:14]) == OpLd) ? ir[3:0] : ir[7:4];
    endfunction

    function automatic logic [3:0] field_rs2(input logic [15:0] ir);
        return ir[3:0];
    endfunction

    function automatic logic [15:0] field_offset(input logic [15:0] ir);
        logic [3:0] off;
        off = (opcode_e'(ir[15:14]) == OpLd) ? ir[7:4] : ir[11:8];
        return {{12{off[3]}}, off};
    endfunction

    function automatic instr_fields_t decode_fields(input logic [15:0] ir);
        instr_fields_t f;
        f.opcode = opcode_e'(ir[15:14]);
        f.aluop  = ir[13:12];
        f.rd     = field_rd(ir);
        f.rs1    = field_rs1(ir);
        f.rs2    = field_rs2(ir);
        f.offset = field_offset(ir);
        return f;
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 16x16 register file: combinational read, synchronous write, async active-low clear.
// Build option: MC_DP_R0_ZERO_EN makes R0 read as zero and ignore writes.
module mc_regfile
    import mc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [3:0]       i_waddr,
    input  logic [DataW-1:0] i_wdata,
    input  logic [3:0]       i_raddr,
    output logic [DataW-1:0] o_rdata
);

    logic [DataW-1:0] r_mem [NumRegs];
    logic             w_we;

`ifdef MC_DP_R0_ZERO_EN
    assign w_we    = i_we && (i_waddr != 4'd0);
    assign o_rdata = (i_raddr == 4'd0) ? '0 : r_mem[i_raddr];
`else
    assign w_we    = i_we;
    assign o_rdata = r_mem[i_raddr];
`endif

    // Storage array; read above sees the pre-edge value on a same-cycle write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle datapath: PC, IPR, IR, TR1, TR2, AR, ALU, two buses and the register file.
// Build option: MC_DP_R0_ZERO_EN (passed through to mc_regfile).
module mc_datapath
    import mc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_wr_en,
    input  logic             pc_src,
    input  logic             ir_wr_en,
    input  logic             ipr_wr_en,
    input  logic             rf_wr_en,
    input  logic             tr1_wr_en,
    input  logic             tr2_wr_en,
    input  logic             alu_en,
    input  logic             dm_wr_en,
    input  logic [3:0]       db_0_s,
    input  logic [3:0]       db_1_s,
    input  logic [1:0]       alu_op,
    output logic [DataW-1:0] instruction,
    output logic             neg,
    output logic [DataW-1:0] im_addr,
    input  logic [DataW-1:0] im_rdata,
    output logic [DataW-1:0] dm_addr,
    output logic [DataW-1:0] dm_wdata,
    output logic             dm_we,
    input  logic [DataW-1:0] dm_rdata
);

    logic [DataW-1:0] r_pc, r_ipr, r_ir, r_tr1, r_tr2, r_ar;
    logic [DataW-1:0] w_db_0, w_db_1, w_alu, w_pc_mux, w_rf_rdata;

    mc_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_we    (rf_wr_en),
        .i_waddr (r_ar[3:0]),
        .i_wdata (w_db_1),
        .i_raddr (r_ar[3:0]),
        .o_rdata (w_rf_rdata)
    );

    // ALU on the temporary registers; carry is dropped
    always_comb begin
        w_alu = '0;
        case (alu_op)
            AluAdd:  w_alu = r_tr1 + r_tr2;
            AluSub:  w_alu = r_tr1 - r_tr2;
            AluOr:   w_alu = r_tr1 | r_tr2;
            default: w_alu = r_tr1 & r_tr2;
        endcase
    end

    // Data bus select; the PC mux is deliberately not a source here to avoid a loop
    always_comb begin
        w_db_1 = '0;
        case (db_1_s)
            Db1Pc:          w_db_1 = r_pc;
            Db1Ipr:         w_db_1 = r_ipr;
            Db1RfA, Db1RfB: w_db_1 = w_rf_rdata;
            Db1Off:         w_db_1 = field_offset(r_ir);
            Db1Alu:         w_db_1 = w_alu;
            Db1Tr2:         w_db_1 = r_tr2;
            Db1Tr1:         w_db_1 = r_tr1;
            Db1DmRd:        w_db_1 = dm_rdata;
            default:        w_db_1 = '0;
        endcase
    end

    assign w_pc_mux = pc_src ? w_db_1 : r_pc + 16'd1;

    // Address bus select
    always_comb begin
        w_db_0 = '0;
        case (db_0_s)
            Db0Pc:    w_db_0 = r_pc;
            Db0Rs1:   w_db_0 = {12'd0, field_rs1(r_ir)};
            Db0Rs2:   w_db_0 = {12'd0, field_rs2(r_ir)};
            Db0Alu:   w_db_0 = w_alu;
            Db0PcMux: w_db_0 = w_pc_mux;
            Db0Rd:    w_db_0 = {12'd0, field_rd(r_ir)};
            Db0Tr1:   w_db_0 = r_tr1;
            default:  w_db_0 = '0;
        endcase
    end

    // Architectural registers; AR follows the address bus every cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc  <= '0;
            r_ipr <= '0;
            r_ir  <= '0;
            r_tr1 <= '0;
            r_tr2 <= '0;
            r_ar  <= '0;
        end else begin
            r_ar <= w_db_0;
            if (ipr_wr_en) r_ipr <= im_rdata;
            if (ir_wr_en)  r_ir  <= im_rdata;
            if (tr1_wr_en) r_tr1 <= w_db_1;
            if (tr2_wr_en) r_tr2 <= w_db_1;
            if (pc_wr_en)  r_pc  <= w_pc_mux;
        end
    end

    assign instruction = r_ir;
    assign neg         = alu_en & w_alu[15];
    assign im_addr     = r_pc;
    assign dm_addr     = r_ar;
    assign dm_wdata    = w_db_1;
    // Gate with reset so no memory write can slip out while held in reset
    assign dm_we       = dm_wr_en & rst;

endmodule
